// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-L2 memory arbiter: default word/address types
// and the arbiter state encoding.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Beat counter must be able to hold the value BLOCK_SIZE itself.
    function automatic int count_width(input int block_size);
        return $clog2(block_size) + 1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-input picker between the ICache and DCache requesters: fixed data
// priority or round-robin on ties, remembering the most recent winner.
module cache_mem_arbiter_rr_arbiter2 #(
    parameter int DATA_FIRST = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_update,
    output logic o_pick_d
);

    logic last_d;

    always_comb begin
        o_pick_d = i_req_d;
        if (i_req_i && i_req_d) begin
            o_pick_d = (DATA_FIRST != 0) ? 1'b1 : ~last_d;
        end
    end

    // Reset to "data went last" so the ICache wins the first tie.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            last_d <= 1'b1;
        end else if (i_update) begin
            last_d <= o_pick_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single L2 memory port between the ICache refill path and the
// DCache refill/write-back path, one block-sized grant at a time.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = $bits(inst_addr_t),
    parameter int DATA_WIDTH = $bits(inst_t),
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_FIRST = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    input  logic                  i_i_re,
    output logic                  o_i_busy,
    output logic [DATA_WIDTH-1:0] o_i_rdata,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic                  i_d_re,
    input  logic                  i_d_we,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_busy,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_busy,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output arb_state_e            o_state
);

    localparam int CW = count_width(BLOCK_SIZE);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_SIZE - 1);

    arb_state_e    state;
    arb_state_e    state_next;
    logic [CW-1:0] count;
    logic          req_i;
    logic          req_d;
    logic          pick_d;
    logic          arb_update;
    logic          beat;

    // Valid/ready contract on each cache port: a request (re/we) must be held
    // while busy is high; a beat transfers in any cycle where the port is
    // granted, its request is high and busy is low.
    assign req_i = i_i_re;
    assign req_d = i_d_re | i_d_we;

    assign arb_update = (state == IDLE) && (req_i || req_d);

    cache_mem_arbiter_rr_arbiter2 #(
        .DATA_FIRST (DATA_FIRST)
    ) u_pick (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_req_i  (req_i),
        .i_req_d  (req_d),
        .i_update (arb_update),
        .o_pick_d (pick_d)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_mem_addr  = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_i_busy    = req_i;
        o_d_busy    = req_d;
        beat        = 1'b0;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = pick_d ? GNT_D : GNT_I;
                end
            end
            GNT_I: begin
                o_mem_addr = i_i_addr;
                o_mem_re   = req_i;
                o_i_busy   = i_mem_busy & req_i;
                beat       = req_i & ~i_mem_busy;
                if (!req_i || (beat && count == LAST_BEAT)) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                // A write wins over a simultaneous read request.
                o_mem_addr  = i_d_addr;
                o_mem_we    = i_d_we;
                o_mem_re    = i_d_re & ~i_d_we;
                o_mem_wdata = i_d_wdata;
                o_d_busy    = i_mem_busy & req_d;
                beat        = req_d & ~i_mem_busy;
                if (!req_d || (beat && count == LAST_BEAT)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (state_next == IDLE) begin
            count <= '0;
        end else if (beat) begin
            count <= count + 1'b1;
        end
    end

    assign o_i_rdata = i_mem_rdata;
    assign o_d_rdata = i_mem_rdata;
    assign o_state   = state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle behavioural model of the
// grant rules, a beat scoreboard, and literal spot checks.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 4;
    localparam int DATA_FIRST = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] i_i_addr;
    logic          i_i_re;
    logic          o_i_busy;
    logic [DW-1:0] o_i_rdata;
    logic [AW-1:0] i_d_addr;
    logic          i_d_re;
    logic          i_d_we;
    logic [DW-1:0] i_d_wdata;
    logic          o_d_busy;
    logic [DW-1:0] o_d_rdata;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_re;
    logic          o_mem_we;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_busy;
    logic [DW-1:0] i_mem_rdata;
    arb_state_e    state_dbg;

    cache_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .DATA_FIRST (DATA_FIRST)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_i_addr    (i_i_addr),
        .i_i_re      (i_i_re),
        .o_i_busy    (o_i_busy),
        .o_i_rdata   (o_i_rdata),
        .i_d_addr    (i_d_addr),
        .i_d_re      (i_d_re),
        .i_d_we      (i_d_we),
        .i_d_wdata   (i_d_wdata),
        .o_d_busy    (o_d_busy),
        .o_d_rdata   (o_d_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_re    (o_mem_re),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_busy  (i_mem_busy),
        .i_mem_rdata (i_mem_rdata),
        .o_state     (state_dbg)
    );

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = ICache, 2 = DCache; beats = beats done this grant.
    int m_owner = 0;
    int m_beats = 0;
    bit m_last_d = 1'b1;

    function automatic bit model_win_d(input bit ri, input bit rd, input bit last_d);
        if (ri && rd) return (DATA_FIRST != 0) || !last_d;
        return rd;
    endfunction

    function automatic bit owner_req(input int owner);
        if (owner == 1) return i_i_re;
        return i_d_re || i_d_we;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  <= 0;
            m_beats  <= 0;
            m_last_d <= 1'b1;
        end else if (m_owner == 0) begin
            if (i_i_re || i_d_re || i_d_we) begin
                m_owner  <= model_win_d(i_i_re, i_d_re || i_d_we, m_last_d) ? 2 : 1;
                m_last_d <= model_win_d(i_i_re, i_d_re || i_d_we, m_last_d);
                m_beats  <= 0;
            end
        end else if (!owner_req(m_owner)) begin
            m_owner <= 0;
            m_beats <= 0;
        end else if (!i_mem_busy) begin
            if (m_beats + 1 == BS) begin
                m_owner <= 0;
                m_beats <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [AW:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_beats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [AW-1:0] e_addr;
        logic          e_re;
        logic          e_we;
        logic [DW-1:0] e_wd;
        logic          e_bi;
        logic          e_bd;
        arb_state_e    e_st;
        logic [AW:0]   e_beat;
        e_addr = '0;
        e_re   = 1'b0;
        e_we   = 1'b0;
        e_wd   = '0;
        e_bi   = i_i_re;
        e_bd   = i_d_re | i_d_we;
        e_st   = IDLE;
        if (m_owner == 1) begin
            e_st   = GNT_I;
            e_addr = i_i_addr;
            e_re   = i_i_re;
            e_bi   = i_i_re & i_mem_busy;
        end else if (m_owner == 2) begin
            e_st   = GNT_D;
            e_addr = i_d_addr;
            e_we   = i_d_we;
            e_re   = i_d_re & ~i_d_we;
            e_wd   = i_d_wdata;
            e_bd   = (i_d_re | i_d_we) & i_mem_busy;
        end
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_re", o_mem_re, e_re);
        chk("mem_we", o_mem_we, e_we);
        chk("mem_wdata", o_mem_wdata, e_wd);
        chk("i_busy", o_i_busy, e_bi);
        chk("d_busy", o_d_busy, e_bd);
        chk("i_rdata", o_i_rdata, i_mem_rdata);
        chk("d_rdata", o_d_rdata, i_mem_rdata);
        chk("state", state_dbg, e_st);
        if ((o_mem_re || o_mem_we) && !i_mem_busy) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_beat @%0t: got addr %0h expected no beat", $time, o_mem_addr);
            end else begin
                e_beat = exp_q.pop_front();
                chk("sb_beat", {o_mem_we, o_mem_addr}, e_beat);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ire, input logic [AW-1:0] iaddr,
                         input logic dre, input logic dwe, input logic [AW-1:0] daddr,
                         input logic [DW-1:0] dwd, input logic mbusy);
        i_i_re      = ire;
        i_i_addr    = iaddr;
        i_d_re      = dre;
        i_d_we      = dwe;
        i_d_addr    = daddr;
        i_d_wdata   = dwd;
        i_mem_busy  = mbusy;
        i_mem_rdata = $urandom();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic push_block(input logic we, input logic [AW-1:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({we, base + AW'(4 * k)});
    endtask

    // ---------------- stimulus ----------------
    int b0;

    initial begin
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, 1'b0);
        rst_n = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        #2;
        chk("rst_mem_re", o_mem_re, 1'b0);
        chk("rst_mem_we", o_mem_we, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_i_busy", o_i_busy, 1'b1);
        chk("rst_d_busy", o_d_busy, 1'b1);
        tick();
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b1;
        tick();

        // Both request on the first arbitration after reset: ICache first.
        b0 = n_beats;
        push_block(1'b0, 32'h200, 4);
        push_block(1'b0, 32'h3000, 4);
        drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h3000, '0, 1'b0);
        #2;
        chk("t2_arb_i_busy", o_i_busy, 1'b1);
        chk("t2_arb_d_busy", o_d_busy, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + AW'(4 * k), 1'b1, 1'b0, 32'h3000, '0, 1'b0);
            #2;
            chk("t2_d_held", o_d_busy, 1'b1);
            if (k == 0) chk("t2_i_first", o_mem_addr, 32'h200);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 32'h3000, '0, 1'b0);
        #2;
        chk("t2_gap_re", o_mem_re, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 32'h3000 + AW'(4 * k), '0, 1'b0);
            #2;
            if (k == 0) chk("t2_d_first", o_mem_addr, 32'h3000);
            tick();
        end
        idle_cycle();
        chk("t2_beats", n_beats - b0, 8);

        // Single ICache refill.
        b0 = n_beats;
        push_block(1'b0, 32'h100, 4);
        drive(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("t1_arb_busy", o_i_busy, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + AW'(4 * k), 1'b0, 1'b0, '0, '0, 1'b0);
            #2;
            chk("t1_beat_re", o_mem_re, 1'b1);
            chk("t1_beat_busy", o_i_busy, 1'b0);
            tick();
        end
        idle_cycle();
        chk("t1_beats", n_beats - b0, 4);

        // DCache write with re and we both high.
        push_block(1'b1, 32'h2000, 1);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0);
        #2;
        chk("t3_we", o_mem_we, 1'b1);
        chk("t3_re", o_mem_re, 1'b0);
        chk("t3_wdata", o_mem_wdata, 32'hDEADBEEF);
        tick();
        idle_cycle();
        idle_cycle();

        // Memory stall of three cycles on the second beat.
        b0 = n_beats;
        push_block(1'b0, 32'h400, 4);
        drive(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h404, 1'b0, 1'b0, '0, '0, 1'b1);
            #2;
            chk("t4_stall_busy", o_i_busy, 1'b1);
            tick();
        end
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 32'h400 + AW'(4 * k), 1'b0, 1'b0, '0, '0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("t4_released", o_mem_re, 1'b0);
        tick();
        chk("t4_beats", n_beats - b0, 4);

        // Early drop by DCache after 2 beats; DCache wins this tie by round-robin.
        b0 = n_beats;
        push_block(1'b0, 32'h5000, 2);
        push_block(1'b0, 32'h600, 4);
        drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h5000, '0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h5000 + AW'(4 * k), '0, 1'b0);
            #2;
            if (k == 0) chk("t5_d_wins", o_mem_addr, 32'h5000);
            tick();
        end
        drive(1'b1, 32'h600, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("t5_drop_re", o_mem_re, 1'b0);
        chk("t5_drop_i_busy", o_i_busy, 1'b1);
        tick();
        drive(1'b1, 32'h600, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("t5_idle_re", o_mem_re, 1'b0);
        chk("t5_idle_state", state_dbg, IDLE);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h600 + AW'(4 * k), 1'b0, 1'b0, '0, '0, 1'b0);
            #2;
            if (k == 0) chk("t5_i_grant", o_mem_addr, 32'h600);
            tick();
        end
        idle_cycle();
        chk("t5_beats", n_beats - b0, 6);

        // Reset in the middle of a burst, then a tie: ICache must win.
        push_block(1'b0, 32'h700, 2);
        drive(1'b1, 32'h700, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h700 + AW'(4 * k), 1'b0, 1'b0, '0, '0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h708, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("t6_pre_rst_re", o_mem_re, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_re", o_mem_re, 1'b0);
        chk("t6_rst_addr", o_mem_addr, 32'h0);
        chk("t6_rst_state", state_dbg, IDLE);
        tick();
        b0 = n_beats;
        push_block(1'b0, 32'h800, 4);
        push_block(1'b0, 32'h9000, 4);
        drive(1'b1, 32'h800, 1'b1, 1'b0, 32'h9000, '0, 1'b0);
        tick();
        drive(1'b1, 32'h800, 1'b1, 1'b0, 32'h9000, '0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h800 + AW'(4 * k), 1'b1, 1'b0, 32'h9000, '0, 1'b0);
            #2;
            if (k == 0) chk("t6_i_wins", o_mem_addr, 32'h800);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 32'h9000, '0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 32'h9000 + AW'(4 * k), '0, 1'b0);
            tick();
        end
        idle_cycle();
        idle_cycle();
        chk("t6_beats", n_beats - b0, 8);

        chk("sb_queue_empty", exp_q.size(), 0);
        chk("total_beats", n_beats, 33);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
